// File: rtl/multi_key_press_classifier.sv
// multi_key_press_classifier
//   Classifies each of N_KEYS debounced buttons independently as a short
//   press, long press, double press or auto-repeat. It runs on the 100 Hz
//   debounce clock. Per-key events are reported as one-cycle pulse vectors.
//   A lowest-index-first event bus serves the input decoder.
//
// Ports
//   clk_db          debounce clock (100 Hz)
//   rst             asynchronous active-high reset
//   btn_i           debounced key levels, 1 = pressed
//   repeat_en_i     per-key auto-repeat enable, sampled every cycle
//   short_press_o   one-cycle short-press pulses
//   long_press_o    one-cycle long-press pulses
//   double_press_o  one-cycle double-press pulses
//   repeat_press_o  one-cycle auto-repeat pulses
//   held_o          level, high while a key is in its long-hold state
//   event_valid_o   some key produced an event this cycle
//   event_key_o     lowest key index with an event (0 when no event)
//   event_code_o    0 short, 1 long, 2 double, 3 repeat (0 when no event)
module multi_key_press_classifier #(
   parameter int N_KEYS           = 4,
   parameter int LONG_TICKS       = 100,
   parameter int DOUBLE_GAP_TICKS = 30,
   parameter int REPEAT_TICKS     = 20,
   localparam int KEY_W           = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
   input  logic              clk_db,
   input  logic              rst,
   input  logic [N_KEYS-1:0] btn_i,
   input  logic [N_KEYS-1:0] repeat_en_i,
   output logic [N_KEYS-1:0] short_press_o,
   output logic [N_KEYS-1:0] long_press_o,
   output logic [N_KEYS-1:0] double_press_o,
   output logic [N_KEYS-1:0] repeat_press_o,
   output logic [N_KEYS-1:0] held_o,
   output logic              event_valid_o,
   output logic [KEY_W-1:0]  event_key_o,
   output logic [1:0]        event_code_o
);

   localparam int MAX_AB    = (LONG_TICKS > DOUBLE_GAP_TICKS) ? LONG_TICKS : DOUBLE_GAP_TICKS;
   localparam int MAX_TICKS = (MAX_AB > REPEAT_TICKS) ? MAX_AB : REPEAT_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);
   localparam bit GAP_EN    = (DOUBLE_GAP_TICKS > 0);
   localparam bit REP_EN    = (REPEAT_TICKS > 0);

   // Each counter is cleared on state entry and counts cycles already spent
   // in the state, so the event fires when it holds TICKS-1 at the edge.
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_TICKS);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = GAP_EN ? CNT_W'(DOUBLE_GAP_TICKS - 1) : '0;
   localparam logic [CNT_W-1:0] REP_LAST  = REP_EN ? CNT_W'(REPEAT_TICKS - 1) : '0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRESS1 = 3'd1,
      ST_WAIT2  = 3'd2,
      ST_PRESS2 = 3'd3,
      ST_LONG   = 3'd4
   } state_e;

   state_e            state_q [N_KEYS];
   state_e            state_d [N_KEYS];
   logic [CNT_W-1:0]  cnt_q   [N_KEYS];
   logic [CNT_W-1:0]  cnt_d   [N_KEYS];
   logic [N_KEYS-1:0] btn_prev_q;
   logic [N_KEYS-1:0] rise_s, rel_s;
   logic [N_KEYS-1:0] short_d, long_d, dbl_d, rep_d, held_d;
   logic [N_KEYS-1:0] short_q, long_q, dbl_q, rep_q, held_q;
   logic              ev_valid_d, ev_valid_q;
   logic [KEY_W-1:0]  ev_key_d, ev_key_q;
   logic [1:0]        ev_code_d, ev_code_q;

   // Saturating increment: the counter never wraps.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == CNT_SAT) begin
         return c;
      end else begin
         return c + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   assign rise_s = btn_i & ~btn_prev_q;
   assign rel_s  = ~btn_i & btn_prev_q;

   // Per-key next-state, counter and event pulse logic.
   always_comb begin
      short_d = '0;
      long_d  = '0;
      dbl_d   = '0;
      rep_d   = '0;
      held_d  = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = sat_inc(cnt_q[i]);
         case (state_q[i])
            ST_IDLE: begin
               cnt_d[i] = '0;
               if (rise_s[i]) begin
                  state_d[i] = ST_PRESS1;
               end else begin
                  state_d[i] = ST_IDLE;
               end
            end
            ST_PRESS1: begin
               // A release on the long edge itself still counts as a short candidate.
               if (rel_s[i]) begin
                  cnt_d[i] = '0;
                  if (GAP_EN) begin
                     state_d[i] = ST_WAIT2;
                  end else begin
                     short_d[i] = 1'b1;
                     state_d[i] = ST_IDLE;
                  end
               end else if (cnt_q[i] == LONG_LAST) begin
                  long_d[i]  = 1'b1;
                  cnt_d[i]   = '0;
                  state_d[i] = ST_LONG;
               end else begin
                  state_d[i] = ST_PRESS1;
               end
            end
            ST_WAIT2: begin
               // On the gap-expiry edge a rise reports the deferred short and starts a new press.
               if (cnt_q[i] == GAP_LAST) begin
                  short_d[i] = 1'b1;
                  cnt_d[i]   = '0;
                  if (rise_s[i]) begin
                     state_d[i] = ST_PRESS1;
                  end else begin
                     state_d[i] = ST_IDLE;
                  end
               end else if (rise_s[i]) begin
                  dbl_d[i]   = 1'b1;
                  cnt_d[i]   = '0;
                  state_d[i] = ST_PRESS2;
               end else begin
                  state_d[i] = ST_WAIT2;
               end
            end
            ST_PRESS2: begin
               cnt_d[i] = '0;
               if (rel_s[i]) begin
                  state_d[i] = ST_IDLE;
               end else begin
                  state_d[i] = ST_PRESS2;
               end
            end
            ST_LONG: begin
               if (rel_s[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = ST_IDLE;
               end else if (!REP_EN || !repeat_en_i[i]) begin
                  // Holding the count at zero restarts the repeat phase on re-enable.
                  cnt_d[i]   = '0;
                  state_d[i] = ST_LONG;
               end else if (cnt_q[i] == REP_LAST) begin
                  rep_d[i]   = 1'b1;
                  cnt_d[i]   = '0;
                  state_d[i] = ST_LONG;
               end else begin
                  state_d[i] = ST_LONG;
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = ST_IDLE;
            end
         endcase
         held_d[i] = (state_d[i] == ST_LONG);
      end
   end

   // Lowest-index-first priority encode of the next-cycle pulses.
   always_comb begin
      ev_valid_d = 1'b0;
      ev_key_d   = '0;
      ev_code_d  = 2'd0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (short_d[i] | long_d[i] | dbl_d[i] | rep_d[i]) begin
            ev_valid_d = 1'b1;
            ev_key_d   = KEY_W'(i);
            if (short_d[i]) begin
               ev_code_d = 2'd0;
            end else if (long_d[i]) begin
               ev_code_d = 2'd1;
            end else if (dbl_d[i]) begin
               ev_code_d = 2'd2;
            end else begin
               ev_code_d = 2'd3;
            end
         end else begin
            ev_valid_d = ev_valid_d;
         end
      end
   end

   // State, counter, edge-detect and output registers.
   always_ff @(posedge clk_db or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
         btn_prev_q <= '0;
         short_q    <= '0;
         long_q     <= '0;
         dbl_q      <= '0;
         rep_q      <= '0;
         held_q     <= '0;
         ev_valid_q <= 1'b0;
         ev_key_q   <= '0;
         ev_code_q  <= 2'd0;
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         btn_prev_q <= btn_i;
         short_q    <= short_d;
         long_q     <= long_d;
         dbl_q      <= dbl_d;
         rep_q      <= rep_d;
         held_q     <= held_d;
         ev_valid_q <= ev_valid_d;
         ev_key_q   <= ev_key_d;
         ev_code_q  <= ev_code_d;
      end
   end

   assign short_press_o  = short_q;
   assign long_press_o   = long_q;
   assign double_press_o = dbl_q;
   assign repeat_press_o = rep_q;
   assign held_o         = held_q;
   assign event_valid_o  = ev_valid_q;
   assign event_key_o    = ev_key_q;
   assign event_code_o   = ev_code_q;

endmodule

// File: tb/tb_multi_key_press_classifier.sv
// Directed bench for multi_key_press_classifier. Cycle t of a scenario is the
// t-th clock edge after the scenario starts driving. Every output is compared
// against hand-computed values once per cycle, 1 ns after the edge.
module tb_multi_key_press_classifier;

   logic       clk_db = 1'b0;
   logic       rst;
   logic [3:0] btn, rep_en, btn0, rep_en0;
   logic [3:0] s_o, l_o, d_o, r_o, h_o, s0_o, l0_o, d0_o, r0_o, h0_o;
   logic       v_o, v0_o;
   logic [1:0] k_o, c_o, k0_o, c0_o;
   logic [24:0] obs, obs0, exp_v;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk_db = ~clk_db;

   multi_key_press_classifier dut (
      .clk_db(clk_db), .rst(rst), .btn_i(btn), .repeat_en_i(rep_en),
      .short_press_o(s_o), .long_press_o(l_o), .double_press_o(d_o),
      .repeat_press_o(r_o), .held_o(h_o), .event_valid_o(v_o),
      .event_key_o(k_o), .event_code_o(c_o));

   multi_key_press_classifier #(.DOUBLE_GAP_TICKS(0)) dut0 (
      .clk_db(clk_db), .rst(rst), .btn_i(btn0), .repeat_en_i(rep_en0),
      .short_press_o(s0_o), .long_press_o(l0_o), .double_press_o(d0_o),
      .repeat_press_o(r0_o), .held_o(h0_o), .event_valid_o(v0_o),
      .event_key_o(k0_o), .event_code_o(c0_o));

   assign obs  = {s_o, l_o, d_o, r_o, h_o, v_o, k_o, c_o};
   assign obs0 = {s0_o, l0_o, d0_o, r0_o, h0_o, v0_o, k0_o, c0_o};

   // Expected-value packer: short, long, double, repeat, held, valid, key, code.
   function automatic logic [24:0] mk(input logic [3:0] s, l, d, r, h,
                                      input logic v, input logic [1:0] k, c);
      return {s, l, d, r, h, v, k, c};
   endfunction

   task automatic step();
      @(posedge clk_db);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn = 4'b0000; rep_en = 4'b0000; btn0 = 4'b0000; rep_en0 = 4'b0000;
      repeat (3) step();
      n_cmp++;
      if (obs !== 25'd0) begin n_err++; $display("FAIL reset got=%h exp=%h", obs, 25'd0); end
      n_cmp++;
      if (obs0 !== 25'd0) begin n_err++; $display("FAIL reset_gap0 got=%h exp=%h", obs0, 25'd0); end
      rst = 1'b0;
   endtask

   task automatic test_short();
      for (int t = 0; t <= 45; t++) begin
         btn = (t < 10) ? 4'b0001 : 4'b0000;
         step();
         exp_v = (t == 40) ? mk(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd0, 2'd0) : 25'd0;
         n_cmp++;
         if (obs !== exp_v) begin n_err++; $display("FAIL short t=%0d got=%h exp=%h", t, obs, exp_v); end
      end
   endtask

   task automatic test_long();
      logic [3:0] h;
      for (int t = 0; t <= 160; t++) begin
         btn = (t < 150) ? 4'b0100 : 4'b0000;
         step();
         h = (t >= 100 && t < 150) ? 4'b0100 : 4'b0000;
         exp_v = (t == 100) ? mk(4'b0, 4'b0100, 4'b0, 4'b0, h, 1'b1, 2'd2, 2'd1)
                            : mk(4'b0, 4'b0, 4'b0, 4'b0, h, 1'b0, 2'd0, 2'd0);
         n_cmp++;
         if (obs !== exp_v) begin n_err++; $display("FAIL long t=%0d got=%h exp=%h", t, obs, exp_v); end
      end
   endtask

   task automatic test_repeat();
      logic [3:0] h;
      rep_en = 4'b0010;
      for (int t = 0; t <= 170; t++) begin
         btn = (t < 160) ? 4'b0010 : 4'b0000;
         step();
         h = (t >= 100 && t < 160) ? 4'b0010 : 4'b0000;
         if (t == 100)
            exp_v = mk(4'b0, 4'b0010, 4'b0, 4'b0, h, 1'b1, 2'd1, 2'd1);
         else if (t == 120 || t == 140)
            exp_v = mk(4'b0, 4'b0, 4'b0, 4'b0010, h, 1'b1, 2'd1, 2'd3);
         else
            exp_v = mk(4'b0, 4'b0, 4'b0, 4'b0, h, 1'b0, 2'd0, 2'd0);
         n_cmp++;
         if (obs !== exp_v) begin n_err++; $display("FAIL repeat t=%0d got=%h exp=%h", t, obs, exp_v); end
      end
      rep_en = 4'b0000;
   endtask

   task automatic test_double();
      for (int t = 0; t <= 50; t++) begin
         btn = (t < 5 || (t >= 15 && t < 20)) ? 4'b1000 : 4'b0000;
         step();
         exp_v = (t == 15) ? mk(4'b0, 4'b0, 4'b1000, 4'b0, 4'b0, 1'b1, 2'd3, 2'd2) : 25'd0;
         n_cmp++;
         if (obs !== exp_v) begin n_err++; $display("FAIL double t=%0d got=%h exp=%h", t, obs, exp_v); end
      end
   endtask

   task automatic test_gap_boundary();
      for (int t = 0; t <= 75; t++) begin
         btn = (t < 5 || (t >= 35 && t < 40)) ? 4'b1000 : 4'b0000;
         step();
         exp_v = (t == 35 || t == 70) ? mk(4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd3, 2'd0) : 25'd0;
         n_cmp++;
         if (obs !== exp_v) begin n_err++; $display("FAIL gap_boundary t=%0d got=%h exp=%h", t, obs, exp_v); end
      end
   endtask

   task automatic test_simultaneous();
      for (int t = 0; t <= 42; t++) begin
         btn = (t < 8) ? 4'b1010 : 4'b0000;
         step();
         exp_v = (t == 38) ? mk(4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd1, 2'd0) : 25'd0;
         n_cmp++;
         if (obs !== exp_v) begin n_err++; $display("FAIL simultaneous t=%0d got=%h exp=%h", t, obs, exp_v); end
      end
   endtask

   task automatic test_gap_disabled();
      for (int t = 0; t <= 12; t++) begin
         btn0 = (t < 8) ? 4'b1010 : 4'b0000;
         step();
         exp_v = (t == 8) ? mk(4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd1, 2'd0) : 25'd0;
         n_cmp++;
         if (obs0 !== exp_v) begin n_err++; $display("FAIL gap_disabled t=%0d got=%h exp=%h", t, obs0, exp_v); end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] h;
      btn = 4'b0001;
      for (int t = 0; t < 60; t++) begin
         step();
         n_cmp++;
         if (obs !== 25'd0) begin n_err++; $display("FAIL pre_reset t=%0d got=%h exp=%h", t, obs, 25'd0); end
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs !== 25'd0) begin n_err++; $display("FAIL reset_async got=%h exp=%h", obs, 25'd0); end
      step();
      step();
      rst = 1'b0;
      for (int t = 0; t <= 105; t++) begin
         step();
         h = (t >= 100) ? 4'b0001 : 4'b0000;
         exp_v = (t == 100) ? mk(4'b0, 4'b0001, 4'b0, 4'b0, h, 1'b1, 2'd0, 2'd1)
                            : mk(4'b0, 4'b0, 4'b0, 4'b0, h, 1'b0, 2'd0, 2'd0);
         n_cmp++;
         if (obs !== exp_v) begin n_err++; $display("FAIL post_reset_long t=%0d got=%h exp=%h", t, obs, exp_v); end
      end
      btn = 4'b0000;
      step();
      n_cmp++;
      if (obs !== 25'd0) begin n_err++; $display("FAIL post_reset_release got=%h exp=%h", obs, 25'd0); end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_repeat();
      test_double();
      test_gap_boundary();
      test_simultaneous();
      test_gap_disabled();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
